// File: rtl/boot_uploader.sv
// Host-side UART boot partner: streams a ROM image to the target, requests the
// memory dump back, and counts echoed words that differ from the ROM.
module boot_uploader #(
  parameter int unsigned ADR_WIDTH         = 6,
  parameter int unsigned IMG_SIZE          = 64,
  parameter int unsigned CLKS_PER_BIT      = 868,
  parameter int unsigned RX_TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 start,
  output logic [ADR_WIDTH-1:0] rom_adr,
  input  logic [15:0]          rom_data,
  output logic                 tx,
  input  logic                 rx,
  output logic                 scan_req,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [ADR_WIDTH:0]   err_count
);

  localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TMO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
  localparam int unsigned ERR_W = ADR_WIDTH + 1;

  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]     BIT_HALF = BIT_W'(CLKS_PER_BIT / 2);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(RX_TIMEOUT_CYCLES - 1);
  localparam logic [ADR_WIDTH-1:0] IDX_LAST = ADR_WIDTH'(IMG_SIZE - 1);
  localparam logic [ERR_W-1:0]     ERR_MAX  = ERR_W'(IMG_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND_HI,
    S_SEND_LO,
    S_WAIT_ECHO,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t               state;
  logic [ADR_WIDTH-1:0] idx;
  logic                 tx_sent;
  logic                 got_hi;
  logic [7:0]           echo_hi;
  logic [7:0]           echo_lo;
  logic [TMO_W-1:0]     tmo_cnt;

  logic                 tx_active;
  logic [8:0]           tx_shift;
  logic [3:0]           tx_bits;
  logic [BIT_W-1:0]     tx_clks;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_active;
  logic [BIT_W-1:0]     rx_cnt;
  logic [3:0]           rx_bits;
  logic [7:0]           rx_shift;
  logic [7:0]           rx_byte;
  logic                 rx_pend;

  logic                 tx_start_c;
  logic [7:0]           tx_byte_c;
  logic                 rx_take_c;

  assign tx_start_c = ce && (state == S_SEND_HI || state == S_SEND_LO) && !tx_sent && !tx_active;
  assign tx_byte_c  = (state == S_SEND_HI) ? rom_data[15:8] : rom_data[7:0];
  // Any pending byte is consumed on a ce cycle; the FSM drops it unless in WAIT_ECHO.
  assign rx_take_c  = ce && rx_pend;

  // UART transmitter: start bit, 8 data bits LSB first, stop bit; free-running timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx        <= 1'b1;
      tx_active <= 1'b0;
      tx_shift  <= '0;
      tx_bits   <= '0;
      tx_clks   <= '0;
    end else if (tx_start_c) begin
      tx        <= 1'b0;
      tx_shift  <= {1'b1, tx_byte_c};
      tx_bits   <= '0;
      tx_clks   <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_clks == BIT_LAST) begin
        tx_clks <= '0;
        if (tx_bits == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          tx       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bits  <= tx_bits + 1'b1;
        end
      end else begin
        tx_clks <= tx_clks + 1'b1;
      end
    end
  end

  // UART receiver: mid-bit sampling, bytes with a low stop bit are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_pend   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (rx_take_c) begin
        rx_pend <= 1'b0;
      end
      if (!rx_active) begin
        if (!rx_s) begin
          rx_active <= 1'b1;
          rx_cnt    <= BIT_HALF;
          rx_bits   <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt  <= BIT_LAST;
        rx_bits <= rx_bits + 1'b1;
        if (rx_bits == 4'd0) begin
          if (rx_s) begin
            rx_active <= 1'b0;
          end
        end else if (rx_bits == 4'd9) begin
          rx_active <= 1'b0;
          if (rx_s) begin
            rx_byte <= rx_shift;
            rx_pend <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
        end
      end
    end
  end

  // Upload / verify sequencer; advances only on ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tx_sent   <= 1'b0;
      got_hi    <= 1'b0;
      echo_hi   <= '0;
      echo_lo   <= '0;
      tmo_cnt   <= '0;
      rom_adr   <= '0;
      scan_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
    end else if (ce) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            idx       <= '0;
            rom_adr   <= '0;
            scan_req  <= 1'b0;
            tx_sent   <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          rom_adr <= idx;
          state   <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (tx_start_c) begin
            tx_sent <= 1'b1;
          end else if (tx_sent && !tx_active) begin
            tx_sent <= 1'b0;
            state   <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (tx_start_c) begin
            tx_sent <= 1'b1;
          end else if (tx_sent && !tx_active) begin
            tx_sent <= 1'b0;
            if (idx == IDX_LAST) begin
              idx      <= '0;
              rom_adr  <= '0;
              got_hi   <= 1'b0;
              tmo_cnt  <= '0;
              scan_req <= 1'b1;
              state    <= S_WAIT_ECHO;
            end else begin
              idx     <= idx + 1'b1;
              rom_adr <= idx + 1'b1;
              state   <= S_FETCH;
            end
          end
        end
        S_WAIT_ECHO: begin
          rom_adr <= idx;
          if (rx_pend) begin
            tmo_cnt <= '0;
            if (!got_hi) begin
              echo_hi <= rx_byte;
              got_hi  <= 1'b1;
            end else begin
              echo_lo <= rx_byte;
              got_hi  <= 1'b0;
              state   <= S_COMPARE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            scan_req <= 1'b0;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          if ({echo_hi, echo_lo} != rom_data && err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
          end
          if (idx == IDX_LAST) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            scan_req <= 1'b0;
            state    <= S_DONE;
          end else begin
            idx     <= idx + 1'b1;
            rom_adr <= idx + 1'b1;
            tmo_cnt <= '0;
            got_hi  <= 1'b0;
            state   <= S_WAIT_ECHO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_uploader.sv
// Directed bench for boot_uploader: ROM model, UART frame monitor on tx and a
// loopback target on rx that echoes (or corrupts, or withholds) the image.
module tb_boot_uploader;

  localparam int unsigned AW  = 4;
  localparam int unsigned IMG = 8;
  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          start;
  logic [AW-1:0] rom_adr;
  logic [15:0]   rom_data;
  logic          tx;
  logic          rx;
  logic          scan_req;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [AW:0]   err_count;

  int            errors = 0;
  int            checks = 0;
  logic          ce_toggle = 1'b0;
  logic          echo_on = 1'b1;
  int            corrupt_idx = -1;
  logic [7:0]    txq[$];

  boot_uploader #(
    .ADR_WIDTH(AW), .IMG_SIZE(IMG), .CLKS_PER_BIT(CPB), .RX_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .rom_adr(rom_adr),
    .rom_data(rom_data), .tx(tx), .rx(rx), .scan_req(scan_req), .busy(busy),
    .done(done), .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address one ce-cycle later.
  always @(posedge clk) if (ce) rom_data <= 16'hA500 + {12'h000, rom_adr};

  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce = ce_toggle ? ~ce : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decode frames on tx at mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx === 1'b1) txq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  // Target model: answers scan_req with the image, optionally corrupting one word.
  initial begin
    logic [15:0] w;
    rx = 1'b1;
    forever begin
      @(negedge clk);
      if (scan_req === 1'b1) begin
        if (echo_on) begin
          for (int k = 0; k < IMG; k++) begin
            w = (k == corrupt_idx) ? 16'h0000 : 16'hA500 + 16'(k);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
          end
        end
        while (scan_req === 1'b1) @(negedge clk);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (ce_toggle ? 2 : 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_frame_seen", 32'(tx), 0);
  endtask

  task automatic check_stream();
    logic [7:0] e;
    check("tx_byte_count", txq.size(), 2 * IMG);
    for (int k = 0; k < txq.size() && k < 2 * IMG; k++) begin
      e = (k % 2 == 0) ? 8'hA5 : 8'(k / 2);
      check("tx_byte", 32'(txq[k]), 32'(e));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_rom_adr", 32'(rom_adr), 0);
    check("rst_scan_req", 32'(scan_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_err_count", 32'(err_count), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean loopback, with first-frame scope and an ignored mid-upload start.
    txq.delete();
    pulse_start();
    check("run1_busy", 32'(busy), 1);
    check("run1_done_low", 32'(done), 0);
    wait_tx_low(50);
    n = 0;
    while (tx === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("start_bit_len", n, CPB);
    pulse_start();
    check("busy_mid_start", 32'(busy), 1);
    wait_done(20000);
    check("run1_err", 32'(err_count), 0);
    check("run1_timeout", 32'(timeout), 0);
    check("run1_scan_req", 32'(scan_req), 0);
    check("run1_busy_end", 32'(busy), 0);
    check_stream();

    // Word 5 echoed as zero.
    corrupt_idx = 5;
    txq.delete();
    pulse_start();
    wait_done(20000);
    check("run2_err", 32'(err_count), 1);
    check("run2_timeout", 32'(timeout), 0);
    check_stream();

    // Restart from DONE clears the count; ce runs at half rate.
    corrupt_idx = -1;
    ce_toggle = 1'b1;
    txq.delete();
    pulse_start();
    check("restart_err_clr", 32'(err_count), 0);
    check("restart_done_clr", 32'(done), 0);
    check("restart_busy", 32'(busy), 1);
    wait_done(40000);
    check("run3_err", 32'(err_count), 0);
    check_stream();
    ce_toggle = 1'b0;
    repeat (4) @(negedge clk);

    // Target silent: timeout after RX_TIMEOUT_CYCLES.
    echo_on = 1'b0;
    pulse_start();
    n = 0;
    while (scan_req !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("run4_scan_req", 32'(scan_req), 1);
    repeat (TO - 5) @(negedge clk);
    check("run4_not_early", 32'(done), 0);
    wait_done(30);
    check("run4_timeout", 32'(timeout), 1);
    check("run4_err", 32'(err_count), 0);
    check("run4_scan_drop", 32'(scan_req), 0);
    echo_on = 1'b1;

    // Reset during the low-byte frame aborts it immediately.
    pulse_start();
    wait_tx_low(50);
    repeat (10 * CPB + CPB / 2) @(negedge clk);
    check("in_lo_frame", 32'(tx), 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    txq.delete();
    pulse_start();
    wait_done(20000);
    check("run5_err", 32'(err_count), 0);
    check_stream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
